io_pwm_ctrl: RTL

//  Memory-mapped PWM/servo peripheral that consumes IO accesses from the processor memory stage.

---
 rtl/io_pwm_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/io_pwm_ctrl.sv
// Memory-mapped PWM peripheral: shadowed duty/period registers that take effect at period boundaries.
// Define IO_PWM_READBACK_EN to enable the register read space; otherwise data_out is tied to zero.
module io_pwm_ctrl #(
   parameter int NUM_CH     = 6,
   parameter int CNT_W      = 32,
   parameter int PERIOD_RST = 1000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_en,
   input  logic              io_we,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   output logic [NUM_CH-1:0] ja
);

   localparam logic [CNT_W-1:0] PERIOD_RST_C = CNT_W'(PERIOD_RST);
   localparam logic [CNT_W-1:0] CNT_ZERO_C   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);

   logic [1:0]        space_s;
   logic [3:0]        idx_s;
   logic              wr_s;
   logic              wr_duty_s;
   logic              wr_period_s;
   logic              wr_ctrl_s;
   logic              clr_s;
   logic              period_zero_s;
   logic              boundary_s;
   logic              load_s;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic [NUM_CH-1:0] ja_nxt_s;

   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  period_sh_r;
   logic [CNT_W-1:0]  period_act_r;
   logic [CNT_W-1:0]  duty_sh_r  [NUM_CH];
   logic [CNT_W-1:0]  duty_act_r [NUM_CH];
   logic [NUM_CH-1:0] en_r;
   logic [NUM_CH-1:0] ja_r;
   logic              pending_r;

   logic              unused_addr_s;

   assign space_s       = mem_addr[13:12];
   assign idx_s         = mem_addr[3:0];
   assign wr_s          = io_en & io_we & (space_s == 2'b01);
   assign unused_addr_s = ^{mem_addr[31:14], mem_addr[11:4]};

   // Write decode: one register target per store
   always_comb begin
      wr_duty_s   = 1'b0;
      wr_period_s = 1'b0;
      wr_ctrl_s   = 1'b0;
      if (wr_s) begin
         case (idx_s)
            4'd6:    wr_period_s = 1'b1;
            4'd7:    wr_ctrl_s   = 1'b1;
            default: wr_duty_s   = ({28'd0, idx_s} < 32'(NUM_CH));
         endcase
      end else begin
         wr_duty_s = 1'b0;
      end
   end

   // Period timing; a zero period reloads every cycle so a new shadow can escape it
   always_comb begin
      period_zero_s = (period_act_r == CNT_ZERO_C);
      boundary_s    = !period_zero_s && (cnt_r == (period_act_r - CNT_ONE_C));
      clr_s         = wr_ctrl_s & data_in[8];
      load_s        = clr_s | boundary_s | period_zero_s;
      cnt_nxt_s     = load_s ? CNT_ZERO_C : (cnt_r + CNT_ONE_C);
      ja_nxt_s      = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         ja_nxt_s[i] = en_r[i] & !period_zero_s & (cnt_r < duty_act_r[i]);
      end
   end

   // Counter and active registers, reloaded from the shadows at a boundary or clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_r        <= CNT_ZERO_C;
         period_act_r <= PERIOD_RST_C;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_act_r[i] <= CNT_ZERO_C;
         end
      end else begin
         cnt_r <= cnt_nxt_s;
         if (load_s) begin
            period_act_r <= period_sh_r;
            for (int i = 0; i < NUM_CH; i++) begin
               duty_act_r[i] <= duty_sh_r[i];
            end
         end
      end
   end

   // Shadow, enable and pending registers; a shadow write beats a same-cycle reload on pending
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         period_sh_r <= PERIOD_RST_C;
         en_r        <= {NUM_CH{1'b0}};
         pending_r   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_sh_r[i] <= CNT_ZERO_C;
         end
      end else begin
         if (load_s) begin
            pending_r <= 1'b0;
         end
         if (wr_period_s || wr_duty_s) begin
            pending_r <= 1'b1;
         end
         if (wr_period_s) begin
            period_sh_r <= data_in[CNT_W-1:0];
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_duty_s && (idx_s == 4'(i))) begin
               duty_sh_r[i] <= data_in[CNT_W-1:0];
            end
         end
         if (wr_ctrl_s) begin
            en_r <= data_in[NUM_CH-1:0];
         end
      end
   end

   // Registered PWM outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ja_r <= {NUM_CH{1'b0}};
      end else begin
         ja_r <= ja_nxt_s;
      end
   end

   assign ja = ja_r;

`ifdef IO_PWM_READBACK_EN
   logic [31:0] rd_s;

   // Same-cycle load data for the M/W latch
   always_comb begin
      rd_s = 32'd0;
      if (io_en && !io_we && (space_s == 2'b10)) begin
         case (idx_s)
            4'd6:    rd_s = 32'(period_sh_r);
            4'd7:    rd_s = 32'(en_r);
            4'd8:    rd_s = 32'(cnt_r);
            4'd9:    rd_s = {31'd0, pending_r};
            default: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  rd_s = (idx_s == 4'(i)) ? 32'(duty_sh_r[i]) : rd_s;
               end
            end
         endcase
      end else begin
         rd_s = 32'd0;
      end
   end

   assign data_out = rd_s;
`else
   assign data_out = 32'd0;
`endif

endmodule
